rgb_to_gray_avalon_st: RTL and testbench

//  Upstream feeder of the Sobel Avalon-ST stage: converts RGB888 pixels to 8-bit luma.

---
 rtl/avalon_st_pkg.sv | 34 +++
 rtl/rgb_luma_pipe.sv | 52 +++++
 rtl/rgb_to_gray_avalon_st.sv | 103 ++++++++++
 tb/tb_rgb_to_gray_avalon_st.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_pkg.sv
// Shared constants for the Avalon-ST image stages: luma weights, RGB field layout,
// framing FSM states and packet length derivation.
package avalon_st_pkg;
  localparam logic [7:0]  COEF_R   = 8'd77;
  localparam logic [7:0]  COEF_G   = 8'd150;
  localparam logic [7:0]  COEF_B   = 8'd29;
  localparam logic [16:0] LUMA_RND = 17'd128;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic {IDLE, IN_PKT} frm_state_e;

  typedef struct packed {
    logic        valid;
    logic        sop;
    logic        eop;
    logic [15:0] pr;
    logic [15:0] pg;
    logic [15:0] pb;
  } luma_s1_t;

  typedef struct packed {
    logic       valid;
    logic       sop;
    logic       eop;
    logic [7:0] y;
  } luma_s2_t;

  function automatic int pkt_len(input int x_size, input int y_size);
    return x_size * y_size;
  endfunction
endpackage

// File: rtl/rgb_luma_pipe.sv
// Two-stage RGB888 -> luma pipe: stage 1 holds the weighted products, stage 2 the
// rounded sum. Both stages move only when en is high, carrying valid/SOP/EOP along.
module rgb_luma_pipe
  import avalon_st_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [23:0] in_data,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic [7:0]  out_data
);
  luma_s1_t s1_q, s1_d;
  luma_s2_t s2_q, s2_d;

  always_comb begin
    s1_d.valid = in_valid;
    s1_d.sop   = in_sop;
    s1_d.eop   = in_eop;
    s1_d.pr    = 16'(COEF_R) * 16'(in_data[R_LSB +: 8]);
    s1_d.pg    = 16'(COEF_G) * 16'(in_data[G_LSB +: 8]);
    s1_d.pb    = 16'(COEF_B) * 16'(in_data[B_LSB +: 8]);
  end

  // Weights sum to 256, so the rounded quotient always fits in 8 bits.
  always_comb begin
    s2_d.valid = s1_q.valid;
    s2_d.sop   = s1_q.sop;
    s2_d.eop   = s1_q.eop;
    s2_d.y     = 8'((17'(s1_q.pr) + 17'(s1_q.pg) + 17'(s1_q.pb) + LUMA_RND) >> 8);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else if (en) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign out_valid = s2_q.valid;
  assign out_sop   = s2_q.sop;
  assign out_eop   = s2_q.eop;
  assign out_data  = s2_q.y;
endmodule

// File: rtl/rgb_to_gray_avalon_st.sv
// RGB888 -> 8-bit luma Avalon-ST stage with packet framing check and sticky error.
// Beats arriving outside a packet are swallowed; over-long packets get EOP forced.
module rgb_to_gray_avalon_st
  import avalon_st_pkg::*;
#(
  parameter int IMG_X_SIZE = 640,
  parameter int IMG_Y_SIZE = 480
) (
  input  logic        csi_clkrst_clk,
  input  logic        csi_clkrst_reset,
  input  logic [23:0] asi_sink1_data,
  input  logic        asi_sink1_startofpacket,
  input  logic        asi_sink1_endofpacket,
  input  logic        asi_sink1_valid,
  output logic        asi_sink1_ready,
  input  logic        aso_source1_ready,
  output logic [7:0]  aso_source1_data,
  output logic        aso_source1_startofpacket,
  output logic        aso_source1_endofpacket,
  output logic        aso_source1_valid,
  output logic        coe_status_pkt_err
);
  localparam int N     = pkt_len(IMG_X_SIZE, IMG_Y_SIZE);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  frm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pkt_err_q, pkt_err_d;
  logic             advance, accept, fwd, fwd_eop;

  assign advance         = !aso_source1_valid || aso_source1_ready;
  assign asi_sink1_ready = advance;
  assign accept          = asi_sink1_valid && advance;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pkt_err_d = pkt_err_q;
    fwd       = 1'b0;
    fwd_eop   = asi_sink1_endofpacket;
    if (accept) begin
      if (asi_sink1_startofpacket) begin
        // A SOP always (re)starts a packet; hitting one mid-packet is a framing fault.
        fwd   = 1'b1;
        cnt_d = CNT_W'(1);
        if (state_q == IN_PKT) pkt_err_d = 1'b1;
        if (N == 1) begin
          state_d = IDLE;
          fwd_eop = 1'b1;
          if (!asi_sink1_endofpacket) pkt_err_d = 1'b1;
        end else if (asi_sink1_endofpacket) begin
          state_d   = IDLE;
          pkt_err_d = 1'b1;
        end else begin
          state_d = IN_PKT;
        end
      end else if (state_q == IDLE) begin
        pkt_err_d = 1'b1;
      end else begin
        fwd = 1'b1;
        if (asi_sink1_endofpacket) begin
          state_d = IDLE;
          if (cnt_q != LAST) pkt_err_d = 1'b1;
        end else if (cnt_q == LAST) begin
          state_d   = IDLE;
          fwd_eop   = 1'b1;
          pkt_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
    if (csi_clkrst_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  assign coe_status_pkt_err = pkt_err_q;

  rgb_luma_pipe u_pipe (
    .clk      (csi_clkrst_clk),
    .rst      (csi_clkrst_reset),
    .en       (advance),
    .in_valid (accept && fwd),
    .in_sop   (asi_sink1_startofpacket),
    .in_eop   (fwd_eop),
    .in_data  (asi_sink1_data),
    .out_valid(aso_source1_valid),
    .out_sop  (aso_source1_startofpacket),
    .out_eop  (aso_source1_endofpacket),
    .out_data (aso_source1_data)
  );
endmodule

// File: tb/tb_rgb_to_gray_avalon_st.sv
// Bench for rgb_to_gray_avalon_st on a 5x5 frame: fixed tables, framing corner cases
// and randomized frames against a beat-list reference model.
module tb_rgb_to_gray_avalon_st;
  localparam int XS = 5, YS = 5, NPIX = XS * YS;

  typedef struct packed {logic [23:0] d; logic sop; logic eop;} beat_t;
  typedef struct packed {logic [7:0] y; logic sop; logic eop;} out_t;
  typedef struct {logic [23:0] rgb; logic [7:0] y;} vec_t;

  logic        clk = 0, rst = 1;
  logic [23:0] sink_data = '0;
  logic        sink_sop = 0, sink_eop = 0, sink_valid = 0, sink_ready;
  logic        src_ready = 1;
  logic [7:0]  src_data;
  logic        src_sop, src_eop, src_valid, pkt_err;

  int total = 0, bad = 0, cyc = 0;
  int acc_cyc = 0, out_cyc = 0;
  bit bp_en = 0;
  beat_t in_q[$];
  out_t  exp_q[$], got_q[$];
  logic  exp_err;

  rgb_to_gray_avalon_st #(.IMG_X_SIZE(XS), .IMG_Y_SIZE(YS)) dut (
    .csi_clkrst_clk           (clk),
    .csi_clkrst_reset         (rst),
    .asi_sink1_data           (sink_data),
    .asi_sink1_startofpacket  (sink_sop),
    .asi_sink1_endofpacket    (sink_eop),
    .asi_sink1_valid          (sink_valid),
    .asi_sink1_ready          (sink_ready),
    .aso_source1_ready        (src_ready),
    .aso_source1_data         (src_data),
    .aso_source1_startofpacket(src_sop),
    .aso_source1_endofpacket  (src_eop),
    .aso_source1_valid        (src_valid),
    .coe_status_pkt_err       (pkt_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) src_ready = bp_en ? !src_ready : 1'b1;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Output monitor: logs every beat that transfers at the coming edge and
  // checks a stalled beat is held unchanged.
  out_t held;
  bit   stalled = 0;
  always begin
    @(negedge clk);
    #2;
    if (rst) stalled = 0;
    else begin
      if (stalled) chk("stall_hold", {src_valid, src_data, src_sop, src_eop}, {1'b1, held});
      if (src_valid && src_ready) begin
        if (got_q.size() == 0) out_cyc = cyc;
        got_q.push_back('{src_data, src_sop, src_eop});
      end
      stalled = src_valid && !src_ready;
      held    = '{src_data, src_sop, src_eop};
    end
  end

  function automatic logic [7:0] luma(input logic [23:0] p);
    int s = 77 * p[23:16] + 150 * p[15:8] + 29 * p[7:0];
    return 8'((s + 128) / 256);
  endfunction

  // Walks the input beat list with the framing rules: n counts beats of the current packet.
  function automatic void model();
    bit inpkt = 0;
    int n = 0;
    out_t o;
    exp_q.delete();
    exp_err = 0;
    foreach (in_q[i]) begin
      o = '{luma(in_q[i].d), in_q[i].sop, in_q[i].eop};
      if (in_q[i].sop) begin
        if (inpkt) exp_err = 1;
        inpkt = 1; n = 1;
        if (in_q[i].eop) begin exp_err = 1; inpkt = 0; end
        exp_q.push_back(o);
      end else if (!inpkt) exp_err = 1;
      else begin
        n++;
        if (in_q[i].eop) begin
          if (n != NPIX) exp_err = 1;
          inpkt = 0;
        end else if (n == NPIX) begin
          exp_err = 1; o.eop = 1; inpkt = 0;
        end
        exp_q.push_back(o);
      end
    end
  endfunction

  task automatic do_reset();
    bp_en = 0; sink_valid = 0; rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    got_q.delete();
  endtask

  task automatic drive(input bit gaps);
    int w;
    foreach (in_q[i]) begin
      if (gaps && $urandom_range(3) == 0) begin sink_valid = 0; @(negedge clk); end
      sink_valid = 1; sink_data = in_q[i].d; sink_sop = in_q[i].sop; sink_eop = in_q[i].eop;
      w = 0;
      #1;
      while (!sink_ready && w < 100) begin @(negedge clk); #1; w++; end
      if (w >= 100) chk("accept_timeout", 0, 1);
      if (i == 0) acc_cyc = cyc;
      @(negedge clk);
    end
    sink_valid = 0; sink_sop = 0; sink_eop = 0;
  endtask

  task automatic run(input string tag, input bit bp, input bit gaps);
    do_reset();
    model();
    bp_en = bp;
    drive(gaps);
    repeat (12) @(negedge clk);
    bp_en = 0;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_pkt_err"}, pkt_err, exp_err);
  endtask

  task automatic gray_frame(input int len, input bit with_eop);
    in_q.delete();
    for (int k = 1; k <= len; k++)
      in_q.push_back('{{8'(k), 8'(k), 8'(k)}, k == 1, with_eop && k == len});
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{24'hFFFFFF, 8'd255};
    tbl[1] = '{24'hFF0000, 8'd77};
    tbl[2] = '{24'h00FF00, 8'd149};
    tbl[3] = '{24'h0000FF, 8'd29};
    tbl[4] = '{24'h000000, 8'd0};

    // reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_valid", src_valid, 0);
    chk("rst_data", src_data, 0);
    chk("rst_sop", src_sop, 0);
    chk("rst_eop", src_eop, 0);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_sink_ready", sink_ready, 1);

    // gray ramp 1..25, full throughput
    gray_frame(NPIX, 1);
    run("ramp", 0, 0);
    chk("ramp_latency", out_cyc - acc_cyc, 2);
    for (int i = 0; i < NPIX && i < got_q.size(); i++)
      chk($sformatf("ramp_const%0d", i), got_q[i], {8'(i + 1), i == 0, i == NPIX - 1});

    // colour table, repeated across one frame
    in_q.delete();
    for (int i = 0; i < NPIX; i++) in_q.push_back('{tbl[i % 5].rgb, i == 0, i == NPIX - 1});
    run("colour", 0, 0);
    for (int i = 0; i < NPIX && i < got_q.size(); i++)
      chk($sformatf("colour_tbl%0d", i), got_q[i].y, tbl[i % 5].y);

    // toggling downstream ready
    gray_frame(NPIX, 1);
    run("bp", 1, 0);
    for (int i = 0; i < NPIX && i < got_q.size(); i++)
      chk($sformatf("bp_const%0d", i), got_q[i].y, i + 1);

    // short frame then a stray beat
    gray_frame(20, 1);
    in_q.push_back('{24'h123456, 1'b0, 1'b0});
    run("short", 0, 0);
    chk("short_len", got_q.size(), 20);
    if (got_q.size() == 20) chk("short_eop", got_q[19].eop, 1);
    chk("short_err", pkt_err, 1);

    // long frame without EOP
    gray_frame(26, 0);
    run("long", 0, 0);
    chk("long_len", got_q.size(), 25);
    if (got_q.size() == 25) chk("long_eop", got_q[24].eop, 1);
    chk("long_err", pkt_err, 1);

    // randomized frames, gaps and backpressure
    for (int it = 0; it < 8; it++) begin
      int nfr = $urandom_range(1, 2);
      in_q.delete();
      for (int f = 0; f < nfr; f++) begin
        int  len = ($urandom_range(0, 3) < 2) ? NPIX : $urandom_range(18, 28);
        bit  drop_eop = ($urandom_range(0, 4) == 0);
        for (int j = 0; j < len; j++)
          in_q.push_back('{24'($urandom), j == 0, (j == len - 1) && !drop_eop});
      end
      run($sformatf("rand%0d", it), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
